// File: rtl/rd_bus_arbiter.sv
// rd_bus_arbiter: shares one read bus between the I-cache and D-cache
// refill engines. One transaction is outstanding at a time; ties are
// broken round-robin, and responses are routed to the current owner.
module rd_bus_arbiter #(
    parameter bit FIRST_PRIO = 1'b1  // 1 = D-cache wins the first tie, 0 = I-cache
) (
    input  logic         clk,
    input  logic         rst_n,
    // requesters
    input  logic         icr_start_rq,
    input  logic [31:0]  icr_rin_addr,
    input  logic         dcr_start_rq,
    input  logic [31:0]  dcr_rin_addr,
    output logic         rqfull_ic,
    output logic         rqfull_dc,
    // read bus request side
    output logic         bus_start_rq,
    output logic [31:0]  bus_rin_addr,
    // read bus response side
    input  logic [127:0] rdat_m_data,
    input  logic         rdat_m_valid,
    input  logic         finish_mrd,
    // routed responses
    output logic         ic_rdat_valid,
    output logic         dc_rdat_valid,
    output logic [127:0] rdat_data,
    output logic         ic_finish_mrd,
    output logic         dc_finish_mrd
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Index 0 = I-cache, index 1 = D-cache throughout.
    state_t            state_q, state_d;
    logic [1:0]        pend_q, pend_d;
    logic [1:0][31:0]  addr_q, addr_d;
    logic              owner_q, owner_d;     // current / last owner, 1 = D-cache
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic              bus_start_q, bus_start_d;

    logic              busy;
    logic              in_wait;
    logic [1:0]        acc;
    logic [1:0]        req;
    logic              pick;

    // Requester-visible status and accepted start pulses.
    always_comb begin
        busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
        in_wait   = (state_q == S_WAIT);
        rqfull_ic = pend_q[0] | (busy & ~owner_q);
        rqfull_dc = pend_q[1] | (busy & owner_q);
        acc       = {dcr_start_rq & ~rqfull_dc, icr_start_rq & ~rqfull_ic};
        req       = pend_q | acc;
        // On a tie the requester that did not own the bus last time wins.
        pick      = (req == 2'b11) ? ~owner_q : req[1];
    end

    // Next-state logic: capture requests, grant in IDLE, clear pending in ISSUE.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q | acc;
        addr_d      = addr_q;
        owner_d     = owner_q;
        bus_addr_d  = bus_addr_q;
        bus_start_d = 1'b0;
        if (acc[0]) addr_d[0] = icr_rin_addr;
        if (acc[1]) addr_d[1] = dcr_rin_addr;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d     = pick;
                    // A same-cycle pulse has not reached addr_q yet, so use addr_d.
                    bus_addr_d  = addr_d[pick];
                    bus_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pend_d[owner_q] = 1'b0;
                state_d         = S_WAIT;
            end
            S_WAIT: begin
                if (finish_mrd) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            addr_q      <= '0;
            owner_q     <= ~FIRST_PRIO;
            bus_addr_q  <= '0;
            bus_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            owner_q     <= owner_d;
            bus_addr_q  <= bus_addr_d;
            bus_start_q <= bus_start_d;
        end
    end

    // Response routing: only the owner sees data/finish, and only in WAIT.
    always_comb begin
        bus_start_rq  = bus_start_q;
        bus_rin_addr  = bus_addr_q;
        rdat_data     = rdat_m_data;
        ic_rdat_valid = in_wait & ~owner_q & rdat_m_valid;
        dc_rdat_valid = in_wait & owner_q & rdat_m_valid;
        ic_finish_mrd = in_wait & ~owner_q & finish_mrd;
        dc_finish_mrd = in_wait & owner_q & finish_mrd;
    end

endmodule
